// File: rtl/midi_uart_bridge_if.sv
// Byte-send handshake between the MIDI bridge (master) and the avr_interface tx port (slave).
interface midi_uart_bridge_if;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic       tx_block;

    modport master (output tx_data, output new_tx_data, input tx_busy, input tx_block);
    modport slave  (input tx_data, input new_tx_data, output tx_busy, output tx_block);
endinterface

// File: rtl/midi_uart_bridge.sv
// MIDI-in to AVR-serial bridge: UART receiver, byte FIFO, gated tx drain, counters and sticky flags.
// Define MIDI_RT_FILTER_EN to drop 0xF8/0xFE real-time bytes before they reach the FIFO.
module midi_uart_bridge #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 31_250,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          midi_in,
    midi_uart_bridge_if.master            avr,
    input  logic                          clear_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              byte_count,
    output logic                          overflow,
    output logic                          framing_err
);
    localparam int unsigned BIT = CLK_HZ / BAUD;
    localparam int unsigned TW  = $clog2(BIT);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic       {T_IDLE, T_GAP} tx_state_e;

    logic            sync1_q, sync2_q, prev_q;
    rx_state_e       rx_q, rx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_valid, ferr_set, byte_ok;

    tx_state_e       tx_q, tx_d;
    logic            gap_q, gap_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            new_tx_q, new_tx_d;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [LW-1:0]   count_q, count_d;
    logic [CNT_W-1:0] bytes_q;
    logic            ovf_q, ferr_q;
    logic            full, push, pop, drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= midi_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_comb begin
        rx_d     = rx_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        rx_valid = 1'b0;
        ferr_set = 1'b0;
        case (rx_q)
            R_IDLE: if (prev_q && !sync2_q) begin
                rx_d    = R_START;
                timer_d = TW'(BIT / 2 - 1);
            end
            R_START: if (timer_q == '0) begin
                if (!sync2_q) begin
                    rx_d     = R_DATA;
                    timer_d  = TW'(BIT - 1);
                    bitcnt_d = '0;
                end else begin
                    rx_d = R_IDLE;
                end
            end else timer_d = timer_q - 1'b1;
            R_DATA: if (timer_q == '0) begin
                shift_d  = {sync2_q, shift_q[7:1]};
                timer_d  = TW'(BIT - 1);
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == 3'd7) rx_d = R_STOP;
            end else timer_d = timer_q - 1'b1;
            R_STOP: if (timer_q == '0) begin
                rx_d = R_IDLE;
                if (sync2_q) rx_valid = 1'b1;
                else         ferr_set = 1'b1;
            end else timer_d = timer_q - 1'b1;
            default: rx_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q     <= R_IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
        end else begin
            rx_q     <= rx_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
        end
    end

`ifdef MIDI_RT_FILTER_EN
    assign byte_ok = rx_valid && (shift_q != 8'hF8) && (shift_q != 8'hFE);
`else
    assign byte_ok = rx_valid;
`endif

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign full = (count_q == LW'(FIFO_DEPTH));
    assign push = byte_ok && (!full || pop);
    assign drop = byte_ok && full && !pop;

    always_comb begin
        tx_d      = tx_q;
        gap_d     = gap_q;
        pop       = 1'b0;
        new_tx_d  = 1'b0;
        tx_data_d = tx_data_q;
        case (tx_q)
            T_IDLE: if ((count_q != '0) && !avr.tx_busy && !avr.tx_block) begin
                pop       = 1'b1;
                tx_data_d = mem[rd_q];
                new_tx_d  = 1'b1;
                gap_d     = 1'b0;
                tx_d      = T_GAP;
            end
            T_GAP: begin
                gap_d = 1'b1;
                if (gap_q) begin
                    gap_d = 1'b0;
                    tx_d  = T_IDLE;
                end
            end
            default: tx_d = T_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q      <= T_IDLE;
            gap_q     <= 1'b0;
            tx_data_q <= '0;
            new_tx_q  <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            bytes_q   <= '0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            new_tx_q  <= new_tx_d;
            count_q   <= count_d;
            if (push) begin
                wr_q    <= wr_q + 1'b1;
                bytes_q <= bytes_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            ovf_q  <= drop     ? 1'b1 : (clear_err ? 1'b0 : ovf_q);
            ferr_q <= ferr_set ? 1'b1 : (clear_err ? 1'b0 : ferr_q);
        end
    end

    assign avr.tx_data     = tx_data_q;
    assign avr.new_tx_data = new_tx_q;
    assign fifo_level      = count_q;
    assign byte_count      = bytes_q;
    assign overflow        = ovf_q;
    assign framing_err     = ferr_q;
endmodule

// File: tb/tb_midi_uart_bridge.sv
// Directed bench for midi_uart_bridge: vector table of single bytes plus overflow, busy and reset sequences.
module tb_midi_uart_bridge;
    localparam int unsigned BIT = 64;
`ifdef MIDI_RT_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       midi_in = 1'b1;
    logic       clear_err = 1'b0;
    logic [4:0] fifo_level;
    logic [7:0] byte_count;
    logic       overflow, framing_err;

    midi_uart_bridge_if avr_if();

    midi_uart_bridge #(.CLK_HZ(2_000_000), .BAUD(31_250), .FIFO_DEPTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .midi_in(midi_in), .avr(avr_if.master),
        .clear_err(clear_err), .fifo_level(fifo_level), .byte_count(byte_count),
        .overflow(overflow), .framing_err(framing_err)
    );

    always #5 clk = ~clk;

    logic [7:0] sent_q[$];
    always @(negedge clk) if (avr_if.new_tx_data) sent_q.push_back(avr_if.tx_data);

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        midi_in = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            midi_in = d[i];
            wait_clk(BIT);
        end
        midi_in = stop;
        wait_clk(BIT);
        midi_in = 1'b1;
        wait_clk(BIT);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       exp_sent;
        logic       exp_ferr;
    } vec_t;

    vec_t        vecs[10];
    logic [7:0]  vdat[10];
    logic        vstop[10];
    int unsigned n0;
    logic [7:0]  model_cnt;

    initial begin
        vdat  = '{8'h90, 8'h3C, 8'h64, 8'h55, 8'hAA, 8'hF8, 8'h80, 8'hFE, 8'h00, 8'hFF};
        vstop = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};
        for (int i = 0; i < 10; i++) begin
            vecs[i].data     = vdat[i];
            vecs[i].stop_ok  = vstop[i];
            vecs[i].exp_sent = vstop[i] && !(FILT && (vdat[i] == 8'hF8 || vdat[i] == 8'hFE));
            vecs[i].exp_ferr = !vstop[i];
        end
        avr_if.tx_busy  = 1'b0;
        avr_if.tx_block = 1'b0;
        model_cnt = '0;

        wait_clk(4);
        check("rst new_tx_data", 32'(avr_if.new_tx_data), 0);
        check("rst tx_data", 32'(avr_if.tx_data), 0);
        check("rst fifo_level", 32'(fifo_level), 0);
        check("rst byte_count", 32'(byte_count), 0);
        check("rst flags", 32'({overflow, framing_err}), 0);
        rst_n = 1'b1;
        wait_clk(20 * BIT);
        check("idle strobes", 32'(sent_q.size()), 0);
        check("idle outputs", 32'({avr_if.tx_data, fifo_level, byte_count, overflow, framing_err}), 0);

        for (int i = 0; i < 10; i++) begin
            n0 = sent_q.size();
            send_byte(vecs[i].data, vecs[i].stop_ok);
            wait_clk(8);
            if (vecs[i].exp_sent) model_cnt = model_cnt + 8'd1;
            check($sformatf("vec%0d strobes", i), 32'(sent_q.size() - n0), 32'(vecs[i].exp_sent));
            if (vecs[i].exp_sent && sent_q.size() > n0)
                check($sformatf("vec%0d tx_data", i), 32'(sent_q[n0]), 32'(vecs[i].data));
            check($sformatf("vec%0d byte_count", i), 32'(byte_count), 32'(model_cnt));
            check($sformatf("vec%0d framing_err", i), 32'(framing_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d fifo_level", i), 32'(fifo_level), 0);
            if (vecs[i].exp_ferr) begin
                clear_err = 1'b1;
                wait_clk(1);
                clear_err = 1'b0;
                wait_clk(1);
                check($sformatf("vec%0d ferr cleared", i), 32'(framing_err), 0);
            end
        end

        n0 = sent_q.size();
        midi_in = 1'b0;
        wait_clk(BIT / 4);
        midi_in = 1'b1;
        wait_clk(2 * BIT);
        check("glitch strobes", 32'(sent_q.size() - n0), 0);
        check("glitch byte_count", 32'(byte_count), 32'(model_cnt));
        check("glitch flags", 32'({overflow, framing_err}), 0);

        avr_if.tx_block = 1'b1;
        n0 = sent_q.size();
        for (int b = 1; b <= 20; b++) send_byte(8'(b), 1'b1);
        model_cnt = model_cnt + 8'd16;
        check("block fifo_level", 32'(fifo_level), 16);
        check("block overflow", 32'(overflow), 1);
        check("block byte_count", 32'(byte_count), 32'(model_cnt));
        check("block strobes", 32'(sent_q.size() - n0), 0);
        avr_if.tx_block = 1'b0;
        wait_clk(16 * 3 + 20);
        check("drain strobes", 32'(sent_q.size() - n0), 16);
        for (int k = 0; k < 16; k++)
            if (sent_q.size() > n0 + k)
                check($sformatf("drain byte%0d", k), 32'(sent_q[n0 + k]), 32'(k + 1));
        check("drain fifo_level", 32'(fifo_level), 0);
        check("overflow still set", 32'(overflow), 1);
        clear_err = 1'b1;
        wait_clk(1);
        clear_err = 1'b0;
        wait_clk(1);
        check("overflow cleared", 32'(overflow), 0);

        avr_if.tx_busy = 1'b1;
        n0 = sent_q.size();
        send_byte(8'h77, 1'b1);
        model_cnt = model_cnt + 8'd1;
        check("busy holds level", 32'(fifo_level), 1);
        check("busy no strobe", 32'(sent_q.size() - n0), 0);
        avr_if.tx_busy = 1'b0;
        wait_clk(8);
        check("busy release strobe", 32'(sent_q.size() - n0), 1);
        if (sent_q.size() > n0) check("busy release data", 32'(sent_q[n0]), 32'h77);
        check("busy byte_count", 32'(byte_count), 32'(model_cnt));

        n0 = sent_q.size();
        midi_in = 1'b0;
        wait_clk(BIT);
        midi_in = 1'b1;
        wait_clk(2 * BIT);
        midi_in = 1'b0;
        wait_clk(BIT);
        rst_n = 1'b0;
        midi_in = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        model_cnt = '0;
        wait_clk(12 * BIT);
        check("abort strobes", 32'(sent_q.size() - n0), 0);
        check("abort byte_count", 32'(byte_count), 0);
        check("abort flags", 32'({overflow, framing_err}), 0);
        send_byte(8'h42, 1'b1);
        wait_clk(8);
        check("after abort strobes", 32'(sent_q.size() - n0), 1);
        if (sent_q.size() > n0) check("after abort data", 32'(sent_q[n0]), 32'h42);
        check("after abort byte_count", 32'(byte_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
